pipe_stage_chain: RTL and testbench

//  Parametrised multi-stage pipeline register with a valid/ready handshake, a stall (hold) and a flush.

---
 rtl/pipe_stage_chain.sv | 75 +++++++
 tb/tb_pipe_stage_chain.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Multi-stage valid/ready pipeline register with hold (freeze) and flush (squash to a supplied value).
// Bubbles collapse: a stage accepts whenever any stage ahead of it, or the downstream consumer, has room.
module pipe_stage_chain #(
  parameter int              DW      = 32,
  parameter int              STAGES  = 2,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold_i,
  input  logic                          flush_i,
  input  logic [DW-1:0]                 flush_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DW-1:0]                 out_data,
  output logic [$clog2(STAGES+1)-1:0]   count
);

  localparam int CW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v;
  logic [DW-1:0]     d [STAGES];
  logic [STAGES-1:0] rdy;
  logic              room;
  logic              stall;
  logic [CW-1:0]     cnt;

  // A stage may load when it is empty or anything ahead of it can move.
  always_comb begin
    room = out_ready;
    rdy  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      room   = room | ~v[i];
      rdy[i] = room;
    end
  end

  assign stall     = hold_i | flush_i;
  assign in_ready  = rdy[0] & ~stall;
  assign out_valid = v[STAGES-1] & ~stall;
  assign out_data  = d[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= RST_VAL;
    end else if (flush_i) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= flush_data;
    end else if (!hold_i) begin
      // Data only moves with a valid source so bubbles never overwrite a held word.
      if (rdy[0]) begin
        v[0] <= in_valid;
        if (in_valid) d[0] <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < STAGES; i++) cnt = cnt + CW'(v[i]);
  end

  assign count = cnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives identical stimulus into STAGES=1,2,4 instances; each is checked every cycle against a
// FIFO model where a word becomes visible once it has seen STAGES-1 unstalled edges.
module tb_pipe_stage_chain;

  localparam logic [31:0] RSTV = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] data;
    int          stamp;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        hold_i;
  logic        flush_i;
  logic [31:0] flush_data;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic f, input logic [31:0] fd,
                               input logic iv, input logic [31:0] id, input logic ordy);
    @(posedge clk);
    #1;
    rst        = r;
    hold_i     = h;
    flush_i    = f;
    flush_data = fd;
    in_valid   = iv;
    in_data    = id;
    out_ready  = ordy;
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_inst
    localparam int S  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int CW = $clog2(S + 1);

    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [CW-1:0] count;

    entry_t      q[$];
    entry_t      e;
    logic [31:0] last_data;
    bit          known = 1'b0;
    int          tick = 0;
    bit          acc_ready;
    bit          front_end;
    bit          exp_valid;
    logic [31:0] exp_data;

    pipe_stage_chain #(.DW(32), .STAGES(S), .RST_VAL(RSTV)) dut (
      .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i), .flush_data(flush_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
    );

    // Monitor: compare against the model mid-cycle, retire the front word on an output handshake.
    always begin
      @(posedge clk);
      #5;
      if (known) begin
        acc_ready = !hold_i && !flush_i && (q.size() < S || out_ready);
        front_end = (q.size() > 0) && (tick - q[0].stamp >= S - 1);
        exp_valid = front_end && !hold_i && !flush_i;
        exp_data  = front_end ? q[0].data : last_data;
        checkOutput($sformatf("S%0d in_ready", S), 64'(in_ready), 64'(acc_ready));
        checkOutput($sformatf("S%0d out_valid", S), 64'(out_valid), 64'(exp_valid));
        checkOutput($sformatf("S%0d out_data", S), 64'(out_data), 64'(exp_data));
        checkOutput($sformatf("S%0d count", S), 64'(count), 64'(q.size()));
        checkOutput($sformatf("S%0d count_bound", S), 64'(int'(count) <= S), 64'(1));
        if (exp_valid && out_ready) begin
          last_data = q[0].data;
          void'(q.pop_front());
        end
      end
    end

    // Model step at the coming edge: clear on reset/flush, otherwise age words and accept input.
    always begin
      @(posedge clk);
      #8;
      if (rst) begin
        q.delete();
        last_data = RSTV;
        known     = 1'b1;
      end else if (known) begin
        if (flush_i) begin
          q.delete();
          last_data = flush_data;
        end else if (!hold_i) begin
          tick++;
          if (in_valid && acc_ready) begin
            e.data  = in_data;
            e.stamp = tick;
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic checkCleared(input logic [31:0] exp_data);
    #4;
    checkOutput("S2 cleared count", 64'(gen_inst[1].count), 64'(0));
    checkOutput("S2 cleared out_valid", 64'(gen_inst[1].out_valid), 64'(0));
    checkOutput("S2 cleared out_data", 64'(gen_inst[1].out_data), 64'(exp_data));
    checkOutput("S4 cleared count", 64'(gen_inst[2].count), 64'(0));
    checkOutput("S4 cleared out_data", 64'(gen_inst[2].out_data), 64'(exp_data));
  endtask

  initial begin
    rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0; flush_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkCleared(RSTV);

    // Streaming 1,2,3 with the consumer always ready.
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 0, 1, 32'(i), 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Backpressure: fill, offer a third word, then drain.
    applyStimulus(0, 0, 0, 0, 1, 32'hA, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'hB, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 32'hC, 0);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Hold on a full pipe with the consumer ready.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 32'h70 + 32'(i), 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 1, 32'h77, 1);
    applyStimulus(0, 0, 0, 0, 1, 32'h77, 1);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Flush a full pipe while offering a word that must be dropped.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 32'h80 + 32'(i), 0);
    applyStimulus(0, 0, 1, 32'h13, 1, 32'hBAD, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkCleared(32'h13);

    // Flush together with hold, then reset mid-stream.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 32'h90 + 32'(i), 0);
    applyStimulus(0, 1, 1, 32'h99, 1, 32'hBAD, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkCleared(32'h99);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 32'hA0 + 32'(i), 1);
    applyStimulus(1, 0, 0, 0, 1, 32'hBAD, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkCleared(RSTV);

    repeat (10000)
      applyStimulus(0, 0, 0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    repeat (2000)
      applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 49) == 0), $urandom,
                    1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #9;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
